// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle between the decryption round controller and the inverse key schedule.
// The master drives the load/advance requests and the slave returns the current round key.
interface aes_inv_key_sched_if;
  logic         start;
  logic [127:0] last_key;
  logic         next;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, last_key, next,
    input  round_key, round_idx, key_valid, busy, done
  );

  modport slave (
    input  start, last_key, next,
    output round_key, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule: loads the round-10 key and steps back to round 0,
// one round per accepted 'next', holding only the current 128-bit round key.
module aes_inv_key_sched (
  input  logic                 clk,
  input  logic                 reset_n,
  aes_inv_key_sched_if.slave   bus
);

  localparam int NR = 10;

  // Forward AES S-box, row-major from byte 0x00 in the top bits down to byte 0xff.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_nx;
  logic [127:0] key_q, key_nx;
  logic [3:0]   idx_q, idx_nx;
  logic         done_q, done_nx;

  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  b0, b1, b2, b3;
  logic [127:0] prev_key;

  // Byte x lives at bit positions 8*(255-x)+7 downto 8*(255-x).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[8*i +: 8] = sbox(w[8*i +: 8]);
    end
    return s;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Undo one forward expansion step: the last three words come from xor-chains,
  // the first needs the RotWord/SubWord/Rcon term of the recovered previous word.
  assign {a0, a1, a2, a3} = key_q;
  assign b3       = a3 ^ a2;
  assign b2       = a2 ^ a1;
  assign b1       = a1 ^ a0;
  assign b0       = a0 ^ sub_word({b3[23:0], b3[31:24]}) ^ {rcon(idx_q), 24'h0};
  assign prev_key = {b0, b1, b2, b3};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      key_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      key_q  <= key_nx;
      idx_q  <= idx_nx;
      done_q <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    key_nx   = key_q;
    idx_nx   = idx_q;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          key_nx   = bus.last_key;
          idx_nx   = 4'(NR);
          state_nx = RUN;
        end
      end
      RUN: begin
        if (bus.next) begin
          if (idx_q != 4'd0) begin
            key_nx = prev_key;
            idx_nx = idx_q - 4'd1;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.round_key = key_q;
  assign bus.round_idx = idx_q;
  assign bus.key_valid = (state == RUN);
  assign bus.busy      = (state == RUN);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched against a word-array inverse key expansion model
// whose S-box is derived from GF(2^8) inversion plus the AES affine map.
module tb_aes_inv_key_sched;

  localparam logic [127:0] FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9   = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_R0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R9   = 128'h55636363000000000000000000000000;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  int   done_count = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_key [11];

  aes_inv_key_sched_if bus();

  aes_inv_key_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done) done_count++;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    logic [7:0] x;
    for (int xi = 0; xi < 256; xi++) begin
      x   = 8'(xi);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[xi] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Run the FIPS-197 word recurrence backwards from w40..w43 down to w0.
  task automatic build_model(input logic [127:0] lk);
    logic [31:0] w [44];
    logic [7:0]  rc [11];
    logic [31:0] t;
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int r = 2; r <= 10; r++) rc[r] = gmul(rc[r-1], 8'h02);
    {w[40], w[41], w[42], w[43]} = lk;
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word_m({t[23:0], t[31:24]}) ^ {rc[i/4], 24'h0};
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_key[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.next = 1'b1;
    for (int i = 0; i < 20 && bus.busy; i++) step();
    bus.next = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b1;
    bus.last_key = FIPS_LAST;
    bus.next = 1'b0;
    step();
    step();
    tests++;
    if ({bus.round_key, bus.round_idx, bus.key_valid, bus.busy, bus.done} !== 135'd0) begin
      fails++;
      $display("[TB] FAIL reset_state got key=%h idx=%0d valid=%b busy=%b done=%b, want all zero",
               bus.round_key, bus.round_idx, bus.key_valid, bus.busy, bus.done);
    end
    bus.start = 1'b0;
    reset_n = 1'b1;
    step();
    tests++;
    if ({bus.key_valid, bus.busy} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL idle_hold got valid=%b busy=%b want 0 0", bus.key_valid, bus.busy);
    end
  endtask

  task automatic test_fips();
    int d0;
    build_model(FIPS_LAST);
    d0 = done_count;
    bus.last_key = FIPS_LAST;
    bus.start = 1'b1;
    bus.next = 1'b1;
    step();
    bus.start = 1'b0;
    for (int r = 10; r >= 0; r--) begin
      tests++;
      if ({bus.key_valid, bus.busy, bus.round_idx, bus.round_key} !== {2'b11, 4'(r), exp_key[r]}) begin
        fails++;
        $display("[TB] FAIL fips_round r=%0d got valid=%b idx=%0d key=%h want idx=%0d key=%h",
                 r, bus.key_valid, bus.round_idx, bus.round_key, r, exp_key[r]);
      end
      if (r == 9 || r == 0) begin
        tests++;
        if (bus.round_key !== (r == 9 ? FIPS_R9 : FIPS_R0)) begin
          fails++;
          $display("[TB] FAIL fips_known r=%0d got %h want %h", r, bus.round_key,
                   (r == 9 ? FIPS_R9 : FIPS_R0));
        end
      end
      step();
    end
    tests++;
    if ({bus.done, bus.key_valid, bus.busy, bus.round_key} !== {3'b100, FIPS_R0}) begin
      fails++;
      $display("[TB] FAIL fips_done got done=%b valid=%b busy=%b key=%h want 1 0 0 %h",
               bus.done, bus.key_valid, bus.busy, bus.round_key, FIPS_R0);
    end
    bus.next = 1'b0;
    step();
    tests++;
    if (bus.done !== 1'b0 || done_count - d0 != 1) begin
      fails++;
      $display("[TB] FAIL fips_done_pulse got done=%b pulses=%0d want 0 1", bus.done, done_count - d0);
    end
  endtask

  task automatic test_backpressure();
    int  r;
    logic nx;
    logic finished;
    build_model(FIPS_LAST);
    bus.last_key = FIPS_LAST;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    r = 10;
    finished = 1'b0;
    for (int i = 0; i < 100 && !finished; i++) begin
      tests++;
      if ({bus.key_valid, bus.round_idx, bus.round_key} !== {1'b1, 4'(r), exp_key[r]}) begin
        fails++;
        $display("[TB] FAIL stall_round cyc=%0d got idx=%0d key=%h want idx=%0d key=%h",
                 i, bus.round_idx, bus.round_key, r, exp_key[r]);
      end
      nx = (i % 3 == 0);
      bus.next = nx;
      step();
      if (nx) begin
        if (r == 0) finished = 1'b1;
        else r--;
      end
    end
    tests++;
    if (!finished || bus.done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stall_done got finished=%b done=%b want 1 1", finished, bus.done);
    end
    bus.next = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int d0;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    build_model(k);
    bus.last_key = k;
    bus.start = 1'b1;
    bus.next = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    tests++;
    if ({bus.round_idx, bus.round_key} !== {4'd5, exp_key[5]}) begin
      fails++;
      $display("[TB] FAIL midrun_r5 got idx=%0d key=%h want 5 %h", bus.round_idx, bus.round_key, exp_key[5]);
    end
    d0 = done_count;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    tests++;
    if ({bus.round_key, bus.round_idx, bus.key_valid, bus.busy, bus.done} !== 135'd0) begin
      fails++;
      $display("[TB] FAIL midrun_reset got key=%h idx=%0d valid=%b busy=%b done=%b want zero",
               bus.round_key, bus.round_idx, bus.key_valid, bus.busy, bus.done);
    end
    bus.next = 1'b0;
    step();
    step();
    tests++;
    if (done_count != d0 || bus.key_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrun_nodone got pulses=%0d valid=%b want 0 0", done_count - d0, bus.key_valid);
    end
    bus.last_key = FIPS_LAST;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    tests++;
    if ({bus.key_valid, bus.round_idx, bus.round_key} !== {1'b1, 4'd10, FIPS_LAST}) begin
      fails++;
      $display("[TB] FAIL midrun_restart got valid=%b idx=%0d key=%h want 1 10 %h",
               bus.key_valid, bus.round_idx, bus.round_key, FIPS_LAST);
    end
    drain();
  endtask

  task automatic test_start_busy();
    logic [127:0] ka;
    ka = {$urandom, $urandom, $urandom, $urandom};
    build_model(ka);
    bus.last_key = ka;
    bus.start = 1'b1;
    bus.next = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    bus.start = 1'b1;
    bus.last_key = ~ka;
    bus.next = 1'b0;
    step();
    bus.start = 1'b0;
    tests++;
    if ({bus.round_idx, bus.round_key} !== {4'd7, exp_key[7]}) begin
      fails++;
      $display("[TB] FAIL busy_start got idx=%0d key=%h want 7 %h", bus.round_idx, bus.round_key, exp_key[7]);
    end
    bus.next = 1'b1;
    for (int r = 7; r >= 0; r--) begin
      tests++;
      if ({bus.key_valid, bus.round_idx, bus.round_key} !== {1'b1, 4'(r), exp_key[r]}) begin
        fails++;
        $display("[TB] FAIL busy_seq r=%0d got idx=%0d key=%h want %h", r, bus.round_idx, bus.round_key, exp_key[r]);
      end
      step();
    end
    tests++;
    if (bus.done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL busy_done got %b want 1", bus.done);
    end
    bus.next = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, kb;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    bus.last_key = ka;
    bus.start = 1'b1;
    bus.next = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 30 && !bus.done; i++) step();
    tests++;
    if (bus.done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_first_done got %b want 1", bus.done);
    end
    build_model(kb);
    bus.last_key = kb;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    tests++;
    if ({bus.key_valid, bus.round_idx, bus.round_key} !== {1'b1, 4'd10, kb}) begin
      fails++;
      $display("[TB] FAIL b2b_reload got valid=%b idx=%0d key=%h want 1 10 %h",
               bus.key_valid, bus.round_idx, bus.round_key, kb);
    end
    step();
    tests++;
    if ({bus.round_idx, bus.round_key} !== {4'd9, exp_key[9]}) begin
      fails++;
      $display("[TB] FAIL b2b_r9 got idx=%0d key=%h want 9 %h", bus.round_idx, bus.round_key, exp_key[9]);
    end
    drain();
  endtask

  task automatic test_zero_key();
    build_model(128'd0);
    bus.last_key = 128'd0;
    bus.start = 1'b1;
    bus.next = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    tests++;
    if ({bus.round_idx, bus.round_key} !== {4'd9, ZERO_R9} || exp_key[9] !== ZERO_R9) begin
      fails++;
      $display("[TB] FAIL zero_r9 got idx=%0d key=%h model=%h want 9 %h",
               bus.round_idx, bus.round_key, exp_key[9], ZERO_R9);
    end
    step();
    tests++;
    if (bus.round_key !== exp_key[8]) begin
      fails++;
      $display("[TB] FAIL zero_r8 got %h want %h", bus.round_key, exp_key[8]);
    end
    drain();
  endtask

  task automatic test_random();
    logic [127:0] k;
    int   r;
    logic nx;
    logic finished;
    for (int n = 0; n < 100; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      build_model(k);
      bus.last_key = k;
      bus.start = 1'b1;
      bus.next = 1'($urandom_range(0, 1));
      step();
      bus.start = 1'b0;
      r = 10;
      finished = 1'b0;
      for (int i = 0; i < 200 && !finished; i++) begin
        tests++;
        if ({bus.key_valid, bus.round_idx, bus.round_key} !== {1'b1, 4'(r), exp_key[r]}) begin
          fails++;
          $display("[TB] FAIL rand_round key#%0d got idx=%0d key=%h want idx=%0d key=%h",
                   n, bus.round_idx, bus.round_key, r, exp_key[r]);
        end
        nx = ($urandom_range(0, 3) != 0);
        bus.next = nx;
        step();
        if (nx) begin
          if (r == 0) finished = 1'b1;
          else r--;
        end
      end
      tests++;
      if (!finished || {bus.done, bus.key_valid} !== 2'b10) begin
        fails++;
        $display("[TB] FAIL rand_done key#%0d got finished=%b done=%b valid=%b want 1 1 0",
                 n, finished, bus.done, bus.key_valid);
      end
      bus.next = 1'b0;
      step();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.next = 1'b0;
    bus.last_key = '0;
    init_sbox();
    test_reset();
    test_fips();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    test_zero_key();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Iterative AES-128 inverse key schedule for the decryption datapath.
- Takes the round-10 (last) round key and walks backwards, producing round keys 10, 9, …, 0 one step at a time.
- The decryption round controller consumes keys in this order; the inverse cipher's AddRoundKey is fed from `round_key`.
- Avoids storing all 11 expanded keys.

Parameters:
- NR, 10, number of AES rounds; fixed for AES-128, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- start  input  1  load request; sampled only in IDLE
- last_key  input  128  round-10 key (w40..w43, w40 in bits [127:96])
- next  input  1  consumer accepts current round_key; advance one round
- round_key  output  128  current round key, registered
- round_idx  output  4  round number of round_key (10 down to 0)
- key_valid  output  1  round_key/round_idx valid
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after round-0 key accepted

Behaviour:
- Reset is synchronous: on a clk edge with reset_n=0, all registers clear.
  - state=IDLE, round_key=0, round_idx=0, key_valid=0, busy=0, done=0.
  - Reset mid-sequence aborts immediately; no done pulse is generated.
- States: IDLE, RUN.
- IDLE:
  - start=1 at an edge → next cycle: round_key=last_key, round_idx=10, key_valid=1, busy=1, state=RUN.
  - Latency from start to first valid key is 1 cycle.
  - start=0 → hold; round_key keeps its last value; key_valid=0.
- RUN:
  - next=0 → hold all outputs (backpressure; any number of cycles).
  - next=1 and round_idx>0 → round_key←prev(round_key, round_idx); round_idx←round_idx−1; key_valid stays 1.
  - next=1 and round_idx=0 → state=IDLE, key_valid=0, busy=0, done=1 for exactly one cycle. round_key keeps the round-0 key.
  - start is ignored while in RUN.
- prev() function, with current key words a0..a3 (a0 = MSW) and r = round_idx:
  - b3 = a3^a2, b2 = a2^a1, b1 = a1^a0.
  - b0 = a0 ^ SubWord(RotWord(b3)) ^ {Rcon[r], 24'h0}.
  - RotWord({x0,x1,x2,x3}) = {x1,x2,x3,x0}.
  - SubWord = forward AES S-box per byte (FIPS-197). Either share the encryption path's S-box lookup or use a local combinational 256-entry table.
  - Rcon[r] for r = 1..10: 01,02,04,08,10,20,40,80,1B,36. Selected combinationally from round_idx.
- Purely combinational next-key logic plus one 128-bit register; one round step per accepted next.
- Full sequence with next held high: start edge + 11 valid cycles, then the done pulse coincides with key_valid=0.
- done and start in the same cycle (IDLE with done=1): start is accepted normally; back-to-back sequences are allowed.

Test Plan:
- FIPS-197 key 2b7e1516…09cf4f3c: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start pulse, next=1 held → round_idx 10 shows d014f9a8…; round 9 = ac7766f319fadc2128d12941575c006e; round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses once; 11 valid cycles total.
- Backpressure: same vector, next toggled 1,0,0,1,… → round_key/round_idx stable during next=0; key sequence identical to the no-stall case.
- Reset mid-run: assert reset_n=0 at round_idx=5 → next cycle all outputs 0, no done; a new start afterwards works from round 10.
- start while busy: pulse start at round_idx=7 with a different last_key → ignored; sequence continues unchanged.
- Back-to-back: start asserted in the done cycle → key_valid=1, round_idx=10 on the following cycle with the new last_key.
- All-zero last_key: the round-9 key must match a software inverse-schedule model (SubWord(0)=63636363 path checked); then run 100 random keys against the reference model.
